// File: rtl/bus_rr_controller.sv
// bus_rr_controller: shares one broadcast bus among drvrs devices.
// Grants requesters in round-robin order, pops one packet from the winner,
// then pushes it to the destination FIFO(s) or drops it.
//
// state | meaning
// IDLE  | waiting for any pndng; picks the round-robin winner into grant
// POP   | re-checks pndng[grant]; pops and captures the packet, or backs off
// PUSH  | decodes the destination id; pushes, broadcasts or drops
//
// All outputs come straight from flops. pop is registered during the POP
// evaluation, so it is visible during the PUSH state. push, D_push and drop
// are registered during the PUSH evaluation, so they are visible during the
// following IDLE cycle. As a result, pop and push can never overlap.
module bus_rr_controller #(
  parameter int              drvrs   = 4,
  parameter int              pckg_sz = 16,
  parameter int              ID_W    = 8,
  parameter logic [ID_W-1:0] BCAST   = {ID_W{1'b1}}
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  output logic [drvrs-1:0]           push,
  output logic [pckg_sz-1:0]         D_push,
  output logic [$clog2(drvrs)-1:0]   grant,
  output logic                       busy,
  output logic                       drop,
  output logic [15:0]                drop_cnt
);

  localparam int GW = $clog2(drvrs);

  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        last_q, last_d;
  logic [pckg_sz-1:0]   data_q, data_d;
  logic [pckg_sz-1:0]   d_push_q, d_push_d;
  logic [drvrs-1:0]     pop_q, pop_d;
  logic [drvrs-1:0]     push_q, push_d;
  logic                 drop_q, drop_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;

  logic [GW-1:0]        winner;
  logic [GW-1:0]        cand;
  logic                 found;
  logic [ID_W-1:0]      dest_id;
  logic                 dest_valid;

  // Round-robin search: first pending device starting at last+1, wrapping.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= drvrs; k++) begin
      cand = GW'((int'(last_q) + k) % drvrs);
      if (!found && pndng[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Destination decode of the captured packet; the source never receives its own packet.
  always_comb begin
    dest_id    = data_q[pckg_sz-1 -: ID_W];
    dest_valid = (32'(dest_id) < 32'(drvrs)) && (32'(dest_id) != 32'(grant_q));
  end

  // Next-state and registered-output computation for the IDLE/POP/PUSH sequence.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    data_d     = data_q;
    d_push_d   = d_push_q;
    drop_cnt_d = drop_cnt_q;
    pop_d      = '0;
    push_d     = '0;
    drop_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = winner;
          state_d = POP;
        end
      end
      POP: begin
        // A withdrawn request leaves last untouched so that device keeps its turn.
        if (pndng[grant_q]) begin
          pop_d[grant_q] = 1'b1;
          data_d         = D_pop[grant_q*pckg_sz +: pckg_sz];
          last_d         = grant_q;
          state_d        = PUSH;
        end else begin
          state_d = IDLE;
        end
      end
      PUSH: begin
        d_push_d = data_q;
        state_d  = IDLE;
        if (dest_id == BCAST) begin
          push_d          = '1;
          push_d[grant_q] = 1'b0;
        end else if (dest_valid) begin
          push_d[GW'(dest_id)] = 1'b1;
        end else begin
          drop_d = 1'b1;
          if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; last resets to drvrs-1 so device 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= GW'(drvrs - 1);
      data_q     <= '0;
      d_push_q   <= '0;
      pop_q      <= '0;
      push_q     <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      data_q     <= data_d;
      d_push_q   <= d_push_d;
      pop_q      <= pop_d;
      push_q     <= push_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pop      = pop_q;
  assign push     = push_q;
  assign D_push   = d_push_q;
  assign grant    = grant_q;
  assign busy     = (state_q != IDLE);
  assign drop     = drop_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_rr_controller.sv
// Bench for bus_rr_controller: device FIFO model, pop/output scoreboard,
// table of single-packet vectors, and hand sequences for the multi-cycle cases.
module tb_bus_rr_controller;

  localparam int N  = 4;
  localparam int PW = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      pndng;
  logic [N*PW-1:0]   D_pop;
  logic [N-1:0]      pop;
  logic [N-1:0]      push;
  logic [PW-1:0]     D_push;
  logic [1:0]        grant;
  logic              busy;
  logic              drop;
  logic [15:0]       drop_cnt;

  bus_rr_controller #(.drvrs(N), .pckg_sz(PW), .ID_W(8), .BCAST(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push), .grant(grant), .busy(busy), .drop(drop),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            src;
    logic [PW-1:0] pkt;
    logic [N-1:0]  msk;
    logic          drp;
  } vec_t;

  typedef struct {
    logic [N-1:0]  msk;
    logic [PW-1:0] data;
    logic          drp;
  } exp_t;

  logic [PW-1:0] fifo [N][8];
  int            head [N];
  int            tail [N];
  logic [N-1:0]  wd_mask;
  logic [N-1:0]  pop_seen;
  int            exp_pop[$];
  exp_t          exp_out[$];
  int            checks = 0;
  int            errors = 0;
  int            exp_drops = 0;
  vec_t          vt [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      pndng[i]          = (head[i] != tail[i]) && wd_mask[i];
      D_pop[i*PW +: PW] = fifo[i][head[i] % 8];
    end
  endtask

  task automatic enqueue(input int src, input logic [PW-1:0] pkt, input logic [N-1:0] msk,
                         input logic drp, input bit lost);
    exp_t e;
    fifo[src][tail[src] % 8] = pkt;
    tail[src]++;
    exp_pop.push_back(src);
    if (!lost) begin
      e.msk  = msk;
      e.data = pkt;
      e.drp  = drp;
      exp_out.push_back(e);
    end
    refresh();
  endtask

  task automatic monitor();
    int   s;
    exp_t e;
    if (pop != '0) begin
      if (exp_pop.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected actual=%b required=none", pop);
      end else begin
        s = exp_pop.pop_front();
        chk("pop_onehot", 64'(pop), 64'(1) << s);
      end
      chk("pop_push_overlap", 64'(push), 64'd0);
    end
    if (push != '0 || drop) begin
      chk("latency_pop_to_push", 64'(pop_seen != '0), 64'd1);
      if (exp_out.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL push_unexpected actual=%b drop=%b required=none", push, drop);
      end else begin
        e = exp_out.pop_front();
        chk("push_mask", 64'(push), 64'(e.msk));
        chk("d_push", 64'(D_push), 64'(e.data));
        chk("drop_pulse", 64'(drop), 64'(e.drp));
      end
    end
  endtask

  // One clock: FIFO pops at the edge, inputs refreshed after it, outputs checked at negedge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        if (pop_seen[i] && head[i] != tail[i]) head[i]++;
      end
    end
    refresh();
    @(negedge clk);
    if (reset) monitor();
    pop_seen = reset ? pop : '0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_pop.size() != 0 || exp_out.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    chk({"drain_", name}, 64'(exp_pop.size() + exp_out.size()), 64'd0);
    chk({"idle_", name}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    wd_mask  = '1;
    pop_seen = '0;
    refresh();

    vt[0] = '{2, 16'h01A5, 4'b0010, 1'b0};
    vt[1] = '{3, 16'hFF3C, 4'b0111, 1'b0};
    vt[2] = '{1, 16'h0155, 4'b0000, 1'b1};
    vt[3] = '{1, 16'h0799, 4'b0000, 1'b1};
    vt[4] = '{0, 16'h03AA, 4'b1000, 1'b0};
    vt[5] = '{0, 16'hFF00, 4'b1110, 1'b0};
    vt[6] = '{3, 16'h0401, 4'b0000, 1'b1};
    vt[7] = '{3, 16'h0077, 4'b0001, 1'b0};
    vt[8] = '{2, 16'hFE12, 4'b0000, 1'b1};

    // Reset held with all devices requesting; round-robin packets preloaded.
    enqueue(0, 16'h0111, 4'b0010, 1'b0, 1'b0);
    enqueue(1, 16'h0022, 4'b0001, 1'b0, 1'b0);
    enqueue(2, 16'h0033, 4'b0001, 1'b0, 1'b0);
    enqueue(3, 16'h0044, 4'b0001, 1'b0, 1'b0);
    enqueue(0, 16'h0155, 4'b0010, 1'b0, 1'b0);
    repeat (3) tick();
    chk("rst_pop", 64'(pop), 64'd0);
    chk("rst_push", 64'(push), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_d_push", 64'(D_push), 64'd0);

    reset = 1'b1;
    tick();
    chk("rel_edge1_pop", 64'(pop), 64'd0);
    chk("rel_edge1_busy", 64'(busy), 64'd1);
    tick();
    chk("rel_edge2_pop", 64'(pop), 64'b0001);
    wait_drain("round_robin", 40);
    chk("rr_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rr_last_grant", 64'(grant), 64'd0);

    // Withdrawal: device 1 drops its request during POP; it must still be served before device 2.
    enqueue(1, 16'h0061, 4'b0001, 1'b0, 1'b0);
    enqueue(2, 16'h0072, 4'b0001, 1'b0, 1'b0);
    tick();
    chk("wd_busy", 64'(busy), 64'd1);
    chk("wd_grant", 64'(grant), 64'd1);
    wd_mask[1] = 1'b0;
    refresh();
    tick();
    chk("wd_no_pop", 64'(pop), 64'd0);
    chk("wd_back_idle", 64'(busy), 64'd0);
    wd_mask[1] = 1'b1;
    refresh();
    wait_drain("withdraw", 30);
    chk("wd_final_grant", 64'(grant), 64'd2);

    // Table of single-packet vectors: unicast, broadcast, drops and id boundaries.
    for (int v = 0; v < 9; v++) begin
      enqueue(vt[v].src, vt[v].pkt, vt[v].msk, vt[v].drp, 1'b0);
      if (vt[v].drp) exp_drops++;
      wait_drain("vector", 20);
      chk("vec_grant", 64'(grant), 64'(vt[v].src));
      chk("vec_drop_cnt", 64'(drop_cnt), 64'(exp_drops));
    end

    // Reset while push is on the bus clears it immediately.
    enqueue(2, 16'h0011, 4'b0001, 1'b0, 1'b0);
    n = 0;
    while (push == '0 && n < 20) begin
      tick();
      n++;
    end
    chk("rstpush_seen", 64'(push), 64'b0001);
    reset = 1'b0;
    #1;
    chk("rstpush_push_clear", 64'(push), 64'd0);
    chk("rstpush_busy", 64'(busy), 64'd0);
    chk("rstpush_drop_cnt", 64'(drop_cnt), 64'd0);
    pop_seen = '0;
    tick();
    reset = 1'b1;
    tick();

    // Reset after pop but before push: packet is lost and not counted as a drop.
    enqueue(3, 16'h0022, 4'b0001, 1'b0, 1'b1);
    n = 0;
    while (pop == '0 && n < 20) begin
      tick();
      n++;
    end
    chk("lost_pop_seen", 64'(pop), 64'b1000);
    reset = 1'b0;
    #1;
    chk("lost_pop_clear", 64'(pop), 64'd0);
    chk("lost_push_clear", 64'(push), 64'd0);
    head[3]  = tail[3];
    pop_seen = '0;
    refresh();
    repeat (2) tick();
    reset = 1'b1;
    repeat (6) tick();
    chk("lost_no_output", 64'(exp_out.size() + exp_pop.size()), 64'd0);
    chk("lost_drop_cnt", 64'(drop_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
